// File: rtl/zone_bank.sv
// zone_bank: tracks up to NUM_ZONES rectangular blobs of flagged pixels per
// video frame from a single raster pixel stream. At end of frame the live
// zones are copied into a snapshot, which is read out by index.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   frame_start                   clear live zones and overflow, enter TRACK
//   frame_end                     end of frame (TRACK -> LATCH)
//   pix_valid, hcount, vcount     flagged pixel and its coordinates
//   rd_idx                        snapshot readout index
//   rd_left/right/top/bottom      snapshot bounds of zone rd_idx (0 if out of range)
//   rd_count                      snapshot pixel count of zone rd_idx
//   zone_valid                    snapshot mask: active && count >= MIN_PIXELS
//   results_valid                 one-cycle pulse, aligned with new snapshot data
//   overflow                      sticky per frame: unmatched pixel, no free zone
//   busy                          high while in TRACK
module zone_bank #(
  parameter int NUM_ZONES  = 4,
  parameter int COORD_W    = 11,
  parameter int MAX_X      = 800,
  parameter int MAX_Y      = 600,
  parameter int MARGIN     = 7,
  parameter int INIT_SIZE  = 10,
  parameter int MIN_PIXELS = 16,
  parameter int CNT_W      = 16,
  localparam int IDX_W     = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic                 frame_end,
  input  logic                 pix_valid,
  input  logic [COORD_W-1:0]   hcount,
  input  logic [COORD_W-1:0]   vcount,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [COORD_W-1:0]   rd_left,
  output logic [COORD_W-1:0]   rd_right,
  output logic [COORD_W-1:0]   rd_top,
  output logic [COORD_W-1:0]   rd_bottom,
  output logic [CNT_W-1:0]     rd_count,
  output logic [NUM_ZONES-1:0] zone_valid,
  output logic                 results_valid,
  output logic                 overflow,
  output logic                 busy
);

  // One extra bit so margin/size additions cannot wrap before clamping.
  typedef logic [COORD_W:0] wide_t;
  localparam wide_t MAXX_W = wide_t'(MAX_X);
  localparam wide_t MAXY_W = wide_t'(MAX_Y);
  localparam wide_t MARG_W = wide_t'(MARGIN);
  localparam wide_t INIT_W = wide_t'(INIT_SIZE);

  typedef enum logic [1:0] {IDLE, TRACK, LATCH} state_t;
  state_t state, state_nx;

  logic [NUM_ZONES-1:0] z_act;
  logic [COORD_W-1:0]   z_left [NUM_ZONES];
  logic [COORD_W-1:0]   z_right[NUM_ZONES];
  logic [COORD_W-1:0]   z_top  [NUM_ZONES];
  logic [COORD_W-1:0]   z_bot  [NUM_ZONES];
  logic [CNT_W-1:0]     z_cnt  [NUM_ZONES];

  logic [COORD_W-1:0]   s_left [NUM_ZONES];
  logic [COORD_W-1:0]   s_right[NUM_ZONES];
  logic [COORD_W-1:0]   s_top  [NUM_ZONES];
  logic [COORD_W-1:0]   s_bot  [NUM_ZONES];
  logic [CNT_W-1:0]     s_cnt  [NUM_ZONES];

  function automatic wide_t sub_clamp(input wide_t a, input wide_t b);
    return (a >= b) ? (a - b) : '0;
  endfunction

  function automatic wide_t add_clamp(input wide_t a, input wide_t b, input wide_t mx);
    wide_t s;
    s = a + b;
    return (s > mx) ? mx : s;
  endfunction

  wide_t hw, vw;
  assign hw = {1'b0, hcount};
  assign vw = {1'b0, vcount};

  logic [NUM_ZONES-1:0] hit;
  logic                 win_any, free_any;
  logic [IDX_W-1:0]     win_idx, free_idx;

  always_comb begin
    hit      = '0;
    win_any  = 1'b0;
    win_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < NUM_ZONES; i++) begin
      hit[i] = z_act[i]
            && (hw >= sub_clamp({1'b0, z_left[i]}, MARG_W))
            && (hw <= add_clamp({1'b0, z_right[i]}, MARG_W, MAXX_W))
            && (vw >= sub_clamp({1'b0, z_top[i]}, MARG_W))
            && (vw <= add_clamp({1'b0, z_bot[i]}, MARG_W, MAXY_W));
      // Lowest index wins both for matching and for allocation.
      if (hit[i] && !win_any) begin
        win_any = 1'b1;
        win_idx = IDX_W'(i);
      end
      if (!z_act[i] && !free_any) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = IDLE;
      TRACK:   if (frame_end) state_nx = LATCH;
      LATCH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (frame_start) state_nx = TRACK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      z_act         <= '0;
      zone_valid    <= '0;
      results_valid <= 1'b0;
      overflow      <= 1'b0;
      for (int unsigned i = 0; i < NUM_ZONES; i++) begin
        z_left[i]  <= '0;
        z_right[i] <= '0;
        z_top[i]   <= '0;
        z_bot[i]   <= '0;
        z_cnt[i]   <= '0;
        s_left[i]  <= '0;
        s_right[i] <= '0;
        s_top[i]   <= '0;
        s_bot[i]   <= '0;
        s_cnt[i]   <= '0;
      end
    end else begin
      state         <= state_nx;
      results_valid <= (state == LATCH);

      // Snapshot copies pre-clear live contents even if frame_start arrives in LATCH.
      if (state == LATCH) begin
        for (int unsigned i = 0; i < NUM_ZONES; i++) begin
          s_left[i]     <= z_left[i];
          s_right[i]    <= z_right[i];
          s_top[i]      <= z_top[i];
          s_bot[i]      <= z_bot[i];
          s_cnt[i]      <= z_cnt[i];
          zone_valid[i] <= z_act[i] && (z_cnt[i] >= CNT_W'(MIN_PIXELS));
        end
      end

      if (frame_start) begin
        z_act    <= '0;
        overflow <= 1'b0;
        for (int unsigned i = 0; i < NUM_ZONES; i++) z_cnt[i] <= '0;
      end else if (state == TRACK && pix_valid) begin
        if (win_any) begin
          if (hcount < z_left[win_idx])  z_left[win_idx]  <= hcount;
          if (hcount > z_right[win_idx]) z_right[win_idx] <= hcount;
          if (vcount < z_top[win_idx])   z_top[win_idx]   <= vcount;
          if (vcount > z_bot[win_idx])   z_bot[win_idx]   <= vcount;
          if (z_cnt[win_idx] != '1) z_cnt[win_idx] <= z_cnt[win_idx] + 1'b1;
        end else if (free_any) begin
          z_act[free_idx]   <= 1'b1;
          z_left[free_idx]  <= COORD_W'(sub_clamp(hw, INIT_W));
          z_right[free_idx] <= COORD_W'(add_clamp(hw, INIT_W, MAXX_W));
          z_top[free_idx]   <= COORD_W'(sub_clamp(vw, INIT_W));
          z_bot[free_idx]   <= COORD_W'(add_clamp(vw, INIT_W, MAXY_W));
          z_cnt[free_idx]   <= CNT_W'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_left   = '0;
    rd_right  = '0;
    rd_top    = '0;
    rd_bottom = '0;
    rd_count  = '0;
    if (32'(rd_idx) < NUM_ZONES) begin
      rd_left   = s_left[rd_idx];
      rd_right  = s_right[rd_idx];
      rd_top    = s_top[rd_idx];
      rd_bottom = s_bot[rd_idx];
      rd_count  = s_cnt[rd_idx];
    end
  end

  assign busy = (state == TRACK);

endmodule

// File: tb/tb_zone_bank.sv
// Testbench for zone_bank: directed vector table, hand-written corner-case
// sequences and randomized traffic checked against a rule-level model.
module tb_zone_bank;
  localparam int NZ = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0, frame_end = 1'b0, pix_valid = 1'b0;
  logic [10:0] hcount = '0, vcount = '0;
  logic [1:0]  rd_idx = '0;
  logic [10:0] rd_left, rd_right, rd_top, rd_bottom;
  logic [15:0] rd_count;
  logic [3:0]  zone_valid;
  logic        results_valid, overflow, busy;

  zone_bank #(
    .NUM_ZONES(4), .COORD_W(11), .MAX_X(800), .MAX_Y(600),
    .MARGIN(7), .INIT_SIZE(10), .MIN_PIXELS(16), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid), .hcount(hcount), .vcount(vcount), .rd_idx(rd_idx),
    .rd_left(rd_left), .rd_right(rd_right), .rd_top(rd_top), .rd_bottom(rd_bottom),
    .rd_count(rd_count), .zone_valid(zone_valid), .results_valid(results_valid),
    .overflow(overflow), .busy(busy)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 = idle, 1 = tracking, 2 = latch.
  int ml[NZ], mr[NZ], mt[NZ], mb[NZ], mc[NZ];
  bit ma[NZ];
  int sl[NZ], sr[NZ], st[NZ], sb[NZ], sc[NZ];
  bit [3:0] szv;
  bit mrv, mov;
  int mst;

  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction
  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_pixel(input int h, input int v);
    int found = -1;
    int fr = -1;
    for (int i = 0; i < NZ; i++) begin
      if (found < 0 && ma[i] &&
          h >= imax(ml[i] - 7, 0) && h <= imin(mr[i] + 7, 800) &&
          v >= imax(mt[i] - 7, 0) && v <= imin(mb[i] + 7, 600)) found = i;
      if (fr < 0 && !ma[i]) fr = i;
    end
    if (found >= 0) begin
      ml[found] = imin(ml[found], h); mr[found] = imax(mr[found], h);
      mt[found] = imin(mt[found], v); mb[found] = imax(mb[found], v);
      mc[found] = imin(mc[found] + 1, 65535);
    end else if (fr >= 0) begin
      ma[fr] = 1;
      ml[fr] = imax(h - 10, 0); mr[fr] = imin(h + 10, 800);
      mt[fr] = imax(v - 10, 0); mb[fr] = imin(v + 10, 600);
      mc[fr] = 1;
    end else begin
      mov = 1;
    end
  endtask

  task automatic model_edge(input bit rst, input bit fs, input bit fe, input bit pv,
                            input int h, input int v);
    if (rst) begin
      mst = 0; mrv = 0; mov = 0; szv = '0;
      for (int i = 0; i < NZ; i++) begin
        ma[i] = 0; ml[i] = 0; mr[i] = 0; mt[i] = 0; mb[i] = 0; mc[i] = 0;
        sl[i] = 0; sr[i] = 0; st[i] = 0; sb[i] = 0; sc[i] = 0;
      end
      return;
    end
    mrv = (mst == 2);
    if (mst == 2)
      for (int i = 0; i < NZ; i++) begin
        sl[i] = ml[i]; sr[i] = mr[i]; st[i] = mt[i]; sb[i] = mb[i]; sc[i] = mc[i];
        szv[i] = ma[i] && (mc[i] >= 16);
      end
    if (fs) begin
      for (int i = 0; i < NZ; i++) begin ma[i] = 0; mc[i] = 0; end
      mov = 0;
      mst = 1;
    end else begin
      if (mst == 1 && pv) model_pixel(h, v);
      if (mst == 1 && fe) mst = 2;
      else if (mst == 2) mst = 0;
    end
  endtask

  task automatic check_all();
    chk("busy", busy, int'(mst == 1));
    chk("overflow", overflow, mov);
    chk("results_valid", results_valid, mrv);
    chk("zone_valid", zone_valid, szv);
    for (int i = 0; i < NZ; i++) begin
      rd_idx = 2'(i);
      #1;
      chk("rd_left", rd_left, sl[i]);
      chk("rd_right", rd_right, sr[i]);
      chk("rd_top", rd_top, st[i]);
      chk("rd_bottom", rd_bottom, sb[i]);
      chk("rd_count", rd_count, sc[i]);
    end
  endtask

  // Apply one cycle of inputs, advance the model at the edge, then compare.
  task automatic step(input bit rst, input bit fs, input bit fe, input bit pv,
                      input int h, input int v);
    @(negedge clk);
    reset = rst; frame_start = fs; frame_end = fe; pix_valid = pv;
    hcount = 11'(h); vcount = 11'(v);
    @(posedge clk);
    model_edge(rst, fs, fe, pv, h, v);
    #1;
    check_all();
  endtask

  task automatic chk_rd(input string nm, input int idx, input int l, input int r,
                        input int t, input int b, input int c);
    rd_idx = 2'(idx);
    #1;
    chk({nm, "_left"}, rd_left, l);
    chk({nm, "_right"}, rd_right, r);
    chk({nm, "_top"}, rd_top, t);
    chk({nm, "_bottom"}, rd_bottom, b);
    chk({nm, "_count"}, rd_count, c);
  endtask

  typedef struct {
    bit fs, fe, pv; int h, v;
    bit busy, rv, ov; int zv;
    bit do_rd; int idx, l, r, t, b, c;
  } vec_t;

  vec_t tbl[12];
  int cx[8] = '{30, 200, 400, 600, 780, 100, 700, 400};
  int cy[8] = '{20, 150, 300, 450, 590, 500, 80, 580};

  initial begin
    bit seen;
    int c, h, v;

    tbl[0]  = '{1,0,0,  0,  0, 1,0,0,0, 0,0,  0,  0,  0,  0,0};
    tbl[1]  = '{0,0,1,100,100, 1,0,0,0, 0,0,  0,  0,  0,  0,0};
    tbl[2]  = '{0,1,0,  0,  0, 0,0,0,0, 0,0,  0,  0,  0,  0,0};
    tbl[3]  = '{0,0,0,  0,  0, 0,1,0,0, 1,0, 90,110, 90,110,1};
    tbl[4]  = '{0,0,0,  0,  0, 0,0,0,0, 1,0, 90,110, 90,110,1};
    tbl[5]  = '{1,0,0,  0,  0, 1,0,0,0, 1,0, 90,110, 90,110,1};
    tbl[6]  = '{0,0,1,  5,  3, 1,0,0,0, 0,0,  0,  0,  0,  0,0};
    tbl[7]  = '{0,0,1,795,598, 1,0,0,0, 0,0,  0,  0,  0,  0,0};
    tbl[8]  = '{0,0,1,  2,  2, 1,0,0,0, 0,0,  0,  0,  0,  0,0};
    tbl[9]  = '{0,1,0,  0,  0, 0,0,0,0, 0,0,  0,  0,  0,  0,0};
    tbl[10] = '{0,0,0,  0,  0, 0,1,0,0, 1,0,  0, 15,  0, 13,2};
    tbl[11] = '{0,0,0,  0,  0, 0,0,0,0, 1,1,785,800,588,600,1};

    // Reset state.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Directed table: single pixel, clamping at both corners, join without wrap.
    for (int i = 0; i < 12; i++) begin
      step(0, tbl[i].fs, tbl[i].fe, tbl[i].pv, tbl[i].h, tbl[i].v);
      chk("tbl_busy", busy, tbl[i].busy);
      chk("tbl_rv", results_valid, tbl[i].rv);
      chk("tbl_ov", overflow, tbl[i].ov);
      chk("tbl_zv", zone_valid, tbl[i].zv);
      if (tbl[i].do_rd)
        chk_rd("tbl_rd", tbl[i].idx, tbl[i].l, tbl[i].r, tbl[i].t, tbl[i].b, tbl[i].c);
    end

    // 20 pixels forming one blob, then an expansion to the right via the margin.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 100, 100);
    for (int i = 1; i < 20; i++) step(0, 0, 0, 1, 95 + (i % 11), 95 + (i / 11) * 5);
    step(0, 0, 0, 1, 115, 100);
    step(0, 0, 1, 0, 0, 0);
    seen = 0;
    for (int k = 0; k < 5 && !seen; k++) begin
      step(0, 0, 0, 0, 0, 0);
      if (results_valid) seen = 1;
    end
    chk("blob_rv_seen", seen, 1);
    chk("blob_zv0", zone_valid[0], 1);
    chk_rd("blob", 0, 90, 115, 90, 110, 21);

    // All zones allocated in index order, then overflow; cleared by frame_start.
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 100 + 200 * i, 100);
    chk("ovf_before", overflow, 0);
    step(0, 0, 0, 1, 100, 400);
    chk("ovf_set", overflow, 1);
    step(0, 0, 1, 0, 0, 0);
    chk("ovf_sticky", overflow, 1);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) chk_rd("alloc", i, 90 + 200 * i, 110 + 200 * i, 90, 110, 1);
    step(0, 1, 0, 0, 0, 0);
    chk("ovf_cleared", overflow, 0);

    // Pixel coincident with frame_end is included; single results_valid pulse.
    step(0, 0, 1, 1, 200, 200);
    chk("fe_pix_rv0", results_valid, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("fe_pix_rv1", results_valid, 1);
    chk_rd("fe_pix", 0, 190, 210, 190, 210, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("fe_pix_rv_drop", results_valid, 0);

    // frame_start and frame_end together: frame_start wins, no snapshot.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 50, 50);
    step(0, 1, 1, 0, 0, 0);
    chk("fs_fe_busy", busy, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("fs_fe_no_rv", results_valid, 0);
    chk_rd("fs_fe_hold", 0, 190, 210, 190, 210, 1);

    // Reset mid-TRACK with overflow set; pixels ignored until frame_start.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 100 + 150 * i, 300);
    chk("rst_pre_ovf", overflow, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk_rd("rst", 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 300, 300);
    step(0, 0, 1, 1, 310, 300);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_idle_rv", results_valid, 0);
    chk("rst_idle_busy", busy, 0);
    chk_rd("rst_idle", 0, 0, 0, 0, 0, 0);

    // Randomized traffic around clustered centres.
    for (int n = 0; n < 2500; n++) begin
      c = $urandom_range(0, 7);
      h = imin(imax(cx[c] + $urandom_range(0, 40) - 20, 0), 800);
      v = imin(imax(cy[c] + $urandom_range(0, 40) - 20, 0), 600);
      step($urandom_range(0, 599) == 0,
           ($urandom_range(0, 39) == 0) || (mst == 0 && $urandom_range(0, 3) == 0),
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 1) == 1, h, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
